// File: rtl/cv32e40p_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_obi_mem_responder
// Brief    : OBI subordinate backed by a word-addressed SRAM model, with
//            in-order delayed responses and a cap on outstanding requests.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_obi_mem_responder #(
    parameter int MEM_WORDS       = 1024,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RESP_LATENCY    = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        gnt_stall_i,
    input  logic        rvalid_stall_i
);

    localparam int c_addr_w = $clog2(MEM_WORDS);
    localparam int c_ptr_w  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_cnt_w  = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_lat_w  = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

    localparam logic [c_lat_w-1:0] c_lat_init = c_lat_w'(RESP_LATENCY - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(MAX_OUTSTANDING - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [31:0]        c_bad_data = 32'hBADC_0FFE;

    logic [31:0]         r_mem [MEM_WORDS];

    logic                r_vld  [MAX_OUTSTANDING];
    logic [c_lat_w-1:0]  r_cnt  [MAX_OUTSTANDING];
    logic [31:0]         r_data [MAX_OUTSTANDING];
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_in_range;
    logic [c_addr_w-1:0] w_word_idx;
    logic [31:0]         w_rd_word;
    logic [31:0]         w_push_data;
    logic                w_push;
    logic                w_pop;
    logic                w_unused_addr;

    assign w_in_range    = ((addr_i >> (c_addr_w + 2)) == 32'd0);
    assign w_word_idx    = addr_i[2 +: c_addr_w];
    assign w_unused_addr = ^addr_i[1:0];

    assign w_rd_word   = w_in_range ? r_mem[w_word_idx] : c_bad_data;
    assign w_push_data = we_i ? 32'd0 : w_rd_word;

    // Grant looks only at the registered count: a same-cycle pop frees no slot.
    assign gnt_o  = req_i & ~gnt_stall_i & (r_count < c_cnt_max);
    assign w_push = req_i & gnt_o;

    assign rvalid_o = r_vld[r_rptr] & (r_cnt[r_rptr] == '0) & ~rvalid_stall_i;
    assign rdata_o  = rvalid_o ? r_data[r_rptr] : 32'd0;
    assign w_pop    = rvalid_o;

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_push && we_i && w_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    r_mem[w_word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_vld[i]  <= 1'b0;
                r_cnt[i]  <= '0;
                r_data[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (w_push && (c_ptr_w'(i) == r_wptr)) begin
                    r_vld[i]  <= 1'b1;
                    r_cnt[i]  <= c_lat_init;
                    r_data[i] <= w_push_data;
                end else begin
                    if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - c_lat_w'(1);
                    end
                    if (w_pop && (c_ptr_w'(i) == r_rptr)) begin
                        r_vld[i] <= 1'b0;
                    end
                end
            end

            if (w_push) begin
                r_wptr <= (r_wptr == c_ptr_last) ? '0 : r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_ptr_last) ? '0 : r_rptr + c_ptr_w'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CV32E40P_ASSERT_ON
    logic        r_pend;
    logic [68:0] r_pend_bus;

    // Request attributes must hold steady while a request waits for grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend     <= 1'b0;
            r_pend_bus <= '0;
        end else begin
            r_pend     <= req_i & ~gnt_o;
            r_pend_bus <= {addr_i, we_i, be_i, wdata_i};
            if (r_pend && req_i) begin
                assert (r_pend_bus == {addr_i, we_i, be_i, wdata_i});
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_obi_mem_responder
// Brief    : Directed self-checking bench; three responders with latencies
//            1, 4 and 3 exercise data path, cap/ordering and reset flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_obi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    logic        req    [3];
    logic        gnt    [3];
    logic [31:0] addr   [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        gstall [3];
    logic        rstall [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cv32e40p_obi_mem_responder #(.MEM_WORDS(1024), .MAX_OUTSTANDING(2), .RESP_LATENCY(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .gnt_stall_i(gstall[0]), .rvalid_stall_i(rstall[0])
    );

    cv32e40p_obi_mem_responder #(.MEM_WORDS(1024), .MAX_OUTSTANDING(2), .RESP_LATENCY(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .gnt_stall_i(gstall[1]), .rvalid_stall_i(rstall[1])
    );

    cv32e40p_obi_mem_responder #(.MEM_WORDS(1024), .MAX_OUTSTANDING(2), .RESP_LATENCY(3)) u_dut2 (
        .clk_i(clk), .rst_ni(rst2_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
        .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]),
        .gnt_stall_i(gstall[2]), .rvalid_stall_i(rstall[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int i, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        req[i]   = r;
        we[i]    = w;
        addr[i]  = a;
        be[i]    = b;
        wdata[i] = d;
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(i, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
            gstall[i] = 1'b0;
            rstall[i] = 1'b0;
        end
        nx(); nx(); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_rvalid%0d", i), {31'd0, rvalid[i]}, 32'd0);
            chk($sformatf("reset_rdata%0d", i), rdata[i], 32'd0);
        end
        nx(); rst_n = 1'b1; rst2_n = 1'b1;

        // Write then read-after-write, latency 1
        nx(); drv(0, 1, 1, 32'h10, 4'hF, 32'hA5A5_1234); #1;
        chk("wr_gnt", {31'd0, gnt[0]}, 32'd1);
        nx(); drv(0, 1, 0, 32'h10, 4'hF, 32'd0); #1;
        chk("rd_gnt", {31'd0, gnt[0]}, 32'd1);
        chk("wr_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("wr_rdata", rdata[0], 32'd0);
        nx(); drv(0, 0, 0, 32'd0, 4'h0, 32'd0); #1;
        chk("rd_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("rd_rdata", rdata[0], 32'hA5A5_1234);
        nx(); #1;
        chk("idle_rvalid", {31'd0, rvalid[0]}, 32'd0);
        chk("idle_rdata", rdata[0], 32'd0);

        // Byte enables
        nx(); drv(0, 1, 1, 32'h20, 4'hF, 32'h1122_3344);
        nx(); drv(0, 1, 1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        nx(); drv(0, 1, 0, 32'h20, 4'hF, 32'd0);
        nx(); drv(0, 0, 0, 32'd0, 4'h0, 32'd0); #1;
        chk("be_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("be_rdata", rdata[0], 32'h11BB_33DD);

        // Out-of-range accesses
        nx(); drv(0, 1, 1, 32'h0, 4'hF, 32'hCAFE_F00D);
        nx(); drv(0, 1, 1, 32'h1000, 4'hF, 32'hDEAD_BEEF);
        nx(); drv(0, 1, 0, 32'h0, 4'hF, 32'd0);
        nx(); drv(0, 1, 0, 32'h0001_0000, 4'hF, 32'd0); #1;
        chk("oor_wr_word0", rdata[0], 32'hCAFE_F00D);
        nx(); drv(0, 0, 0, 32'd0, 4'h0, 32'd0); #1;
        chk("oor_rd_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("oor_rd_rdata", rdata[0], 32'hBADC_0FFE);

        // rvalid stall for two cycles, unaligned address
        nx(); drv(0, 1, 0, 32'h13, 4'hF, 32'd0);
        nx(); drv(0, 0, 0, 32'd0, 4'h0, 32'd0); rstall[0] = 1'b1; #1;
        chk("rs_hold1_rvalid", {31'd0, rvalid[0]}, 32'd0);
        chk("rs_hold1_rdata", rdata[0], 32'd0);
        nx(); #1;
        chk("rs_hold2_rvalid", {31'd0, rvalid[0]}, 32'd0);
        nx(); rstall[0] = 1'b0; #1;
        chk("rs_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("rs_rdata", rdata[0], 32'hA5A5_1234);

        // Grant stall for three cycles
        nx(); gstall[0] = 1'b1; drv(0, 1, 0, 32'h20, 4'hF, 32'd0); #1;
        chk("gs_gnt0", {31'd0, gnt[0]}, 32'd0);
        nx(); #1;
        chk("gs_gnt1", {31'd0, gnt[0]}, 32'd0);
        nx(); #1;
        chk("gs_gnt2", {31'd0, gnt[0]}, 32'd0);
        nx(); gstall[0] = 1'b0; #1;
        chk("gs_gnt_rel", {31'd0, gnt[0]}, 32'd1);
        nx(); drv(0, 0, 0, 32'd0, 4'h0, 32'd0); #1;
        chk("gs_rdata", rdata[0], 32'h11BB_33DD);

        // Outstanding cap, latency 4
        nx(); drv(1, 1, 1, 32'h4, 4'hF, 32'h1111_1111);
        nx(); drv(1, 1, 1, 32'h8, 4'hF, 32'h2222_2222);
        nx(); drv(1, 0, 0, 32'd0, 4'h0, 32'd0);
        repeat (5) nx();
        nx(); drv(1, 1, 0, 32'h4, 4'hF, 32'd0); #1;
        chk("cap_g0", {31'd0, gnt[1]}, 32'd1);
        nx(); drv(1, 1, 0, 32'h8, 4'hF, 32'd0); #1;
        chk("cap_g1", {31'd0, gnt[1]}, 32'd1);
        nx(); drv(1, 1, 0, 32'h4, 4'hF, 32'd0); #1;
        chk("cap_g2_blocked", {31'd0, gnt[1]}, 32'd0);
        nx(); #1;
        chk("cap_g3_blocked", {31'd0, gnt[1]}, 32'd0);
        chk("cap_early_rvalid", {31'd0, rvalid[1]}, 32'd0);
        nx(); #1;
        chk("cap_rv0", {31'd0, rvalid[1]}, 32'd1);
        chk("cap_rd0", rdata[1], 32'h1111_1111);
        chk("cap_g4_blocked", {31'd0, gnt[1]}, 32'd0);
        nx(); #1;
        chk("cap_g_freed", {31'd0, gnt[1]}, 32'd1);
        chk("cap_rv1", {31'd0, rvalid[1]}, 32'd1);
        chk("cap_rd1", rdata[1], 32'h2222_2222);
        nx(); drv(1, 0, 0, 32'd0, 4'h0, 32'd0); #1;
        chk("cap_rv_gap", {31'd0, rvalid[1]}, 32'd0);
        nx(); nx(); nx(); #1;
        chk("cap_rv2", {31'd0, rvalid[1]}, 32'd1);
        chk("cap_rd2", rdata[1], 32'h1111_1111);

        // Reset mid-transaction, latency 3
        nx(); drv(2, 1, 1, 32'h14, 4'hF, 32'h5EED_5EED);
        nx(); drv(2, 0, 0, 32'd0, 4'h0, 32'd0);
        repeat (4) nx();
        nx(); drv(2, 1, 0, 32'h0, 4'hF, 32'd0); #1;
        chk("rst_g0", {31'd0, gnt[2]}, 32'd1);
        nx(); drv(2, 1, 0, 32'h4, 4'hF, 32'd0); #1;
        chk("rst_g1", {31'd0, gnt[2]}, 32'd1);
        nx(); drv(2, 0, 0, 32'd0, 4'h0, 32'd0); rst2_n = 1'b0; #1;
        chk("rst_rv_in", {31'd0, rvalid[2]}, 32'd0);
        chk("rst_count_in", 32'(u_dut2.r_count), 32'd0);
        nx(); #1;
        chk("rst_rv_in2", {31'd0, rvalid[2]}, 32'd0);
        nx(); rst2_n = 1'b1; #1;
        chk("rst_rv_rel", {31'd0, rvalid[2]}, 32'd0);
        nx(); #1;
        chk("rst_rv_post", {31'd0, rvalid[2]}, 32'd0);
        chk("rst_count_post", 32'(u_dut2.r_count), 32'd0);
        nx(); drv(2, 1, 0, 32'h14, 4'hF, 32'd0); #1;
        chk("rst_new_gnt", {31'd0, gnt[2]}, 32'd1);
        nx(); drv(2, 0, 0, 32'd0, 4'h0, 32'd0); #1;
        chk("rst_new_early", {31'd0, rvalid[2]}, 32'd0);
        nx(); nx(); #1;
        chk("rst_mem_rvalid", {31'd0, rvalid[2]}, 32'd1);
        chk("rst_mem_rdata", rdata[2], 32'h5EED_5EED);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
